// File: rtl/div_pkg.sv
// Shared constants and FSM encoding for the divider and its BCD readout stage.
package div_pkg;

  localparam int DIV_WIDTH  = 8;
  localparam int BCD_DIGITS = 3;

  // Counter must reach DIV_WIDTH, hence the +1.
  localparam int CNT_W = $clog2(DIV_WIDTH + 1);

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_CONVERT = 2'd1;
  localparam state_t ST_DONE    = 2'd2;

endpackage

// File: rtl/div_bcd_formatter_if.sv
// Input (quotient/remainder) and output (BCD) handshakes of the formatter.
interface div_bcd_formatter_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);

  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      quotient;
  logic [WIDTH-1:0]      remainder;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   q_bcd;
  logic [4*DIGITS-1:0]   r_bcd;

  // master: whoever feeds operands and consumes results
  modport master (
    output in_valid, quotient, remainder, out_ready,
    input  in_ready, out_valid, q_bcd, r_bcd
  );

  // slave: the formatter itself
  modport slave (
    input  in_valid, quotient, remainder, out_ready,
    output in_ready, out_valid, q_bcd, r_bcd
  );

endinterface

// File: rtl/bcd_dabble_step.sv
// One double-dabble step: add 3 to every digit >= 5, then shift {bcd, bin} left.
module bcd_dabble_step #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic [4*DIGITS-1:0] bcd_i,
  input  logic [WIDTH-1:0]    bin_i,
  output logic [4*DIGITS-1:0] bcd_o,
  output logic [WIDTH-1:0]    bin_o
);

  logic [4*DIGITS-1:0] adj;

  // Per-digit correction; digits are independent, no carry between them.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    assign adj[4*g +: 4] = (bcd_i[4*g +: 4] >= 4'd5) ? bcd_i[4*g +: 4] + 4'd3
                                                     : bcd_i[4*g +: 4];
  end

  // Binary MSB moves into BCD bit 0; the adjusted BCD MSB falls off (never set in range).
  assign bcd_o = {adj[4*DIGITS-2:0], bin_i[WIDTH-1]};
  assign bin_o = {bin_i[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/div_bcd_formatter.sv
// Sequential binary-to-BCD formatter for the divider's quotient and remainder.
module div_bcd_formatter
  import div_pkg::*;
#(
  parameter int WIDTH  = DIV_WIDTH,
  parameter int DIGITS = BCD_DIGITS
) (
  input logic              clk,
  input logic              rst,
  div_bcd_formatter_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] q_bin_q, q_bin_d, r_bin_q, r_bin_d;
  logic [BW-1:0]   q_bcd_q, q_bcd_d, r_bcd_q, r_bcd_d;

  logic [WIDTH-1:0] q_bin_nx, r_bin_nx;
  logic [BW-1:0]    q_bcd_nx, r_bcd_nx;

  bcd_dabble_step #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_step_q (
    .bcd_i (q_bcd_q),
    .bin_i (q_bin_q),
    .bcd_o (q_bcd_nx),
    .bin_o (q_bin_nx)
  );

  bcd_dabble_step #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_step_r (
    .bcd_i (r_bcd_q),
    .bin_i (r_bin_q),
    .bcd_o (r_bcd_nx),
    .bin_o (r_bin_nx)
  );

  // Next-state: accept in IDLE, one dabble step per clock in CONVERT, hold in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_bin_d = q_bin_q;
    r_bin_d = r_bin_q;
    q_bcd_d = q_bcd_q;
    r_bcd_d = r_bcd_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          q_bin_d = bus.quotient;
          r_bin_d = bus.remainder;
          q_bcd_d = '0;
          r_bcd_d = '0;
          cnt_d   = '0;
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        q_bin_d = q_bin_nx;
        r_bin_d = r_bin_nx;
        q_bcd_d = q_bcd_nx;
        r_bcd_d = r_bcd_nx;
        cnt_d   = cnt_q + CW'(1);
        // Last of WIDTH steps lands on this edge.
        if (cnt_q == CW'(WIDTH - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset discards any conversion in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      q_bin_q <= '0;
      r_bin_q <= '0;
      q_bcd_q <= '0;
      r_bcd_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_bin_q <= q_bin_d;
      r_bin_q <= r_bin_d;
      q_bcd_q <= q_bcd_d;
      r_bcd_q <= r_bcd_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.q_bcd     = q_bcd_q;
  assign bus.r_bcd     = r_bcd_q;

endmodule

// File: tb/tb_div_bcd_formatter.sv
// Randomized self-checking bench for div_bcd_formatter against a decimal-arithmetic model.
module tb_div_bcd_formatter;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_bcd_formatter_if #(.WIDTH(8), .DIGITS(3)) bus ();

  div_bcd_formatter #(.WIDTH(8), .DIGITS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [11:0] bcd3(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full transaction; called at a negedge, returns at a negedge with the block idle.
  task automatic run_one(input int q, input int r, input int stall);
    int k;
    logic [11:0] eq, er;
    eq = bcd3(q);
    er = bcd3(r);
    k = 0;
    while (!bus.in_ready && k < 20) begin step(); k++; end
    chk("idle_before", bus.in_ready, 1'b1);
    bus.in_valid  = 1'b1;
    bus.quotient  = 8'(q);
    bus.remainder = 8'(r);
    bus.out_ready = (stall == 0);
    step();
    bus.in_valid  = 1'b0;
    bus.quotient  = 8'($urandom);
    bus.remainder = 8'($urandom);
    chk("in_ready_low", bus.in_ready, 1'b0);
    k = 0;
    while (!bus.out_valid && k < 20) begin
      step();
      k++;
      bus.quotient = 8'($urandom);
    end
    chk("latency", k, 8);
    chk("q_bcd", bus.q_bcd, eq);
    chk("r_bcd", bus.r_bcd, er);
    for (int s = 0; s < stall; s++) begin
      bus.in_valid  = 1'b1;
      bus.quotient  = 8'($urandom);
      bus.remainder = 8'($urandom);
      step();
      chk("hold_valid", bus.out_valid, 1'b1);
      chk("hold_q", bus.q_bcd, eq);
      chk("hold_r", bus.r_bcd, er);
      chk("hold_in_ready", bus.in_ready, 1'b0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("back_idle_valid", bus.out_valid, 1'b0);
    chk("back_idle_ready", bus.in_ready, 1'b1);
  endtask

  initial begin
    int qv [3];
    int rv [3];
    int acc_cyc [$];
    logic [11:0] gq [$];
    logic [11:0] gr [$];
    int idx;
    bit seen;

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.quotient  = '0;
    bus.remainder = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_q", bus.q_bcd, 12'h000);
    chk("rst_r", bus.r_bcd, 12'h000);
    rst = 1'b0;

    run_one(11, 7, 0);
    run_one(255, 255, 0);
    run_one(0, 0, 0);
    run_one(100, 9, 5);

    // Abort in the 4th CONVERT cycle.
    bus.in_valid  = 1'b1;
    bus.quotient  = 8'd77;
    bus.remainder = 8'd55;
    step();
    bus.in_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_in_ready", bus.in_ready, 1'b1);
    chk("abort_out_valid", bus.out_valid, 1'b0);
    chk("abort_q", bus.q_bcd, 12'h000);
    chk("abort_r", bus.r_bcd, 12'h000);
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (bus.out_valid) seen = 1'b1;
    end
    chk("abort_no_result", seen, 1'b0);
    run_one(42, 3, 0);

    // Back-to-back stream with in_valid held.
    qv = '{1, 99, 200};
    rv = '{0, 98, 13};
    idx = 0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.quotient  = 8'(qv[0]);
    bus.remainder = 8'(rv[0]);
    for (int c = 0; c < 60 && (idx < 3 || gq.size() < 3); c++) begin
      bit acc;
      acc = bus.in_ready && bus.in_valid;
      if (bus.out_valid && bus.out_ready) begin
        gq.push_back(bus.q_bcd);
        gr.push_back(bus.r_bcd);
      end
      step();
      if (acc) begin
        acc_cyc.push_back(cyc);
        idx++;
        if (idx < 3) begin
          bus.quotient  = 8'(qv[idx]);
          bus.remainder = 8'(rv[idx]);
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    chk("b2b_acc_count", acc_cyc.size(), 3);
    chk("b2b_res_count", gq.size(), 3);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk("b2b_interval", acc_cyc[i] - acc_cyc[i-1], 10);
    for (int i = 0; i < gq.size() && i < 3; i++) begin
      chk("b2b_q", gq[i], bcd3(qv[i]));
      chk("b2b_r", gr[i], bcd3(rv[i]));
    end

    // Randomized operands and backpressure.
    for (int t = 0; t < 12; t++)
      run_one(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 3)));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
